// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detector_param
//  Brief    : Parametrised serial sequence detector. Pattern value/length,
//             Mealy or Moore output and overlapping or restarting detection
//             are set by parameters. An internal clock-enable divider
//             produces the sample tick, so the design is one clock domain.
//             The next-state function is a KMP-style table built at
//             elaboration time.
//  Options  : define SEQ_DET_MATCH_CNT_EN to build the saturating match
//             counter; without it match_cnt is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_detector_param #(
  parameter int                 PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0] PATTERN = 5'b10010,
  parameter int                 MOORE   = 0,
  parameter int                 OVERLAP = 1,
  parameter int                 DIV     = 1,
  parameter int                 CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rest,
  input  logic                         w,
  input  logic                         en,
  output logic                         z,
  output logic                         tick,
  output logic [$clog2(PAT_LEN+1)-1:0] state,
  output logic [CNT_W-1:0]             match_cnt
);

  // --------------------------------------------------------------------------
  // Elaboration-time helpers for building the transition table
  // --------------------------------------------------------------------------

  // Pattern bit by arrival order: index 0 is the first bit received.
  function automatic logic pat_bit(input int idx);
    logic [PAT_LEN-1:0] v;
    v = PATTERN >> (PAT_LEN - 1 - idx);
    return v[0];
  endfunction

  // Longest pattern prefix that is a suffix of (prefix of length k) + b.
  function automatic int kmp_next(input int k, input logic b);
    int   best;
    int   pos;
    logic ok;
    logic sb;
    best = 0;
    for (int l = 1; l <= PAT_LEN; l++) begin
      if (l <= k + 1) begin
        ok = 1'b1;
        for (int i = 0; i < l; i++) begin
          pos = k + 1 - l + i;
          sb  = (pos == k) ? b : pat_bit(pos);
          if (sb != pat_bit(i)) ok = 1'b0;
        end
        if (ok) best = l;
      end
    end
    return best;
  endfunction

  // Longest proper prefix of the pattern that is also its suffix.
  function automatic int kmp_fail();
    int   best;
    logic ok;
    best = 0;
    for (int l = 1; l < PAT_LEN; l++) begin
      ok = 1'b1;
      for (int i = 0; i < l; i++) begin
        if (pat_bit(PAT_LEN - l + i) != pat_bit(i)) ok = 1'b0;
      end
      if (ok) best = l;
    end
    return best;
  endfunction

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int C_ST_W      = $clog2(PAT_LEN + 1);
  localparam int C_NUM_ST    = (MOORE != 0) ? PAT_LEN + 1 : PAT_LEN;
  localparam int C_RESTART   = (OVERLAP != 0) ? kmp_fail() : 0;
  localparam int C_DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int C_TAB_DEPTH = 2 ** C_ST_W;

  localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(DIV - 1);
  localparam logic [C_ST_W-1:0]  C_ST_IDLE  = '0;
  localparam logic [C_ST_W-1:0]  C_ST_LAST  = C_ST_W'(PAT_LEN - 1);
  localparam logic [C_ST_W-1:0]  C_ST_MATCH = C_ST_W'(PAT_LEN);
  localparam logic               C_LAST_BIT = PATTERN[0];

  // Full transition for state code k on bit b, including the match wrap-around
  // and recovery of unused encodings to state 0.
  function automatic int tab_entry(input int k, input logic b);
    if (k >= C_NUM_ST) begin
      return 0;
    end
    if ((MOORE != 0) && (k == PAT_LEN)) begin
      return kmp_next(C_RESTART, b);
    end
    if ((MOORE == 0) && (k == PAT_LEN - 1) && (b == pat_bit(PAT_LEN - 1))) begin
      return C_RESTART;
    end
    return kmp_next(k, b);
  endfunction

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic [C_DIV_W-1:0] r_div_cnt;
  logic               r_tick;
  logic [C_ST_W-1:0]  r_state;
  logic [C_ST_W-1:0]  w_next_state;
  logic               w_sample;
  logic [C_ST_W-1:0]  w_tab0 [C_TAB_DEPTH];
  logic [C_ST_W-1:0]  w_tab1 [C_TAB_DEPTH];

  // Transition table, one entry per state code (every code covered).
  genvar gk;
  generate
    for (gk = 0; gk < C_TAB_DEPTH; gk++) begin : g_kmp_tab
      localparam int C_N0 = tab_entry(gk, 1'b0);
      localparam int C_N1 = tab_entry(gk, 1'b1);
      assign w_tab0[gk] = C_ST_W'(C_N0);
      assign w_tab1[gk] = C_ST_W'(C_N1);
    end
  endgenerate

  // Free-running divider; tick is registered so it is low during reset.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_tick    <= (r_div_cnt == C_DIV_LAST);
      r_div_cnt <= (r_div_cnt == C_DIV_LAST) ? '0 : r_div_cnt + 1'b1;
    end
  end

  assign w_sample = r_tick & en;

  // State register.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_state <= C_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state lookup; the state only moves on a sample.
  always_comb begin
    w_next_state = r_state;
    if (w_sample) begin
      w_next_state = w ? w_tab1[r_state] : w_tab0[r_state];
    end
  end

  // Output decode: Mealy looks at the live input, Moore only at the state.
  always_comb begin
    z = 1'b0;
    if (MOORE != 0) begin
      z = (r_state == C_ST_MATCH);
    end else begin
      z = (r_state == C_ST_LAST) && (w == C_LAST_BIT);
    end
  end

  assign tick  = r_tick;
  assign state = r_state;

`ifdef SEQ_DET_MATCH_CNT_EN
  logic             w_match;
  logic [CNT_W-1:0] r_match_cnt;

  // A match event is a sample that completes the pattern.
  always_comb begin
    w_match = 1'b0;
    if (MOORE != 0) begin
      w_match = w_sample && (w_next_state == C_ST_MATCH);
    end else begin
      w_match = w_sample && (r_state == C_ST_LAST) && (w == C_LAST_BIT);
    end
  end

  // Saturating match counter.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_match_cnt <= '0;
    end else if (w_match && (r_match_cnt != {CNT_W{1'b1}})) begin
      r_match_cnt <= r_match_cnt + 1'b1;
    end
  end

  assign match_cnt = r_match_cnt;
`else
  assign match_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_detector_param
//  Brief    : Directed self-checking bench for seq_detector_param. Five
//             instances cover Mealy/overlap, Mealy/no-overlap, Moore,
//             DIV=4 and a 2-bit counter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

`ifdef SEQ_DET_MATCH_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic       clk;
  logic       rest;
  logic       w_a, w_d, w_c;
  logic       en_on, en_d;

  logic       z_def, tick_def;  logic [2:0] st_def;  logic [7:0] cnt_def;
  logic       z_nov, tick_nov;  logic [2:0] st_nov;  logic [7:0] cnt_nov;
  logic       z_moo, tick_moo;  logic [2:0] st_moo;  logic [7:0] cnt_moo;
  logic       z_div, tick_div;  logic [2:0] st_div;  logic [7:0] cnt_div;
  logic       z_c,   tick_c;    logic [2:0] st_c;    logic [1:0] cnt_c;

  int n_vec = 0;
  int n_err = 0;

  seq_detector_param u_def (
    .clk(clk), .rest(rest), .w(w_a), .en(en_on),
    .z(z_def), .tick(tick_def), .state(st_def), .match_cnt(cnt_def));

  seq_detector_param #(.OVERLAP(0)) u_nov (
    .clk(clk), .rest(rest), .w(w_a), .en(en_on),
    .z(z_nov), .tick(tick_nov), .state(st_nov), .match_cnt(cnt_nov));

  seq_detector_param #(.MOORE(1)) u_moo (
    .clk(clk), .rest(rest), .w(w_a), .en(en_on),
    .z(z_moo), .tick(tick_moo), .state(st_moo), .match_cnt(cnt_moo));

  seq_detector_param #(.DIV(4)) u_div (
    .clk(clk), .rest(rest), .w(w_d), .en(en_d),
    .z(z_div), .tick(tick_div), .state(st_div), .match_cnt(cnt_div));

  seq_detector_param #(.OVERLAP(0), .CNT_W(2)) u_cnt (
    .clk(clk), .rest(rest), .w(w_c), .en(en_on),
    .z(z_c), .tick(tick_c), .state(st_c), .match_cnt(cnt_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // Assert reset for two cycles and release it on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rest = 1'b0; w_a = 1'b0; w_d = 1'b0; w_c = 1'b0; en_d = 1'b1;
    repeat (2) @(negedge clk);
    rest = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rest = 1'b0; w_a = 1'b1;
    #1;
    n_vec++; if (st_def !== 3'd0) begin n_err++; $display("FAIL reset_state_def: got %0d expected 0", st_def); end
    n_vec++; if (st_moo !== 3'd0) begin n_err++; $display("FAIL reset_state_moore: got %0d expected 0", st_moo); end
    n_vec++; if (z_def !== 1'b0) begin n_err++; $display("FAIL reset_z_mealy: got %b expected 0", z_def); end
    n_vec++; if (z_moo !== 1'b0) begin n_err++; $display("FAIL reset_z_moore: got %b expected 0", z_moo); end
    n_vec++; if (tick_def !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b expected 0", tick_def); end
    n_vec++; if (tick_div !== 1'b0) begin n_err++; $display("FAIL reset_tick_div: got %b expected 0", tick_div); end
    n_vec++; if (cnt_def !== 8'd0) begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", cnt_def); end
    rest = 1'b1;
  endtask

  // 1,0,0,1,0,0,1,0 on Mealy/overlap, Mealy/no-overlap and Moore/overlap.
  task automatic test_stream();
    logic [7:0] bits;
    logic [7:0] ez_def, ez_nov, ez_moo;
    int es_def [8];
    int es_nov [8];
    int es_moo [8];
    bits   = 8'b1001_0010;
    ez_def = 8'b0000_1001;
    ez_nov = 8'b0000_1000;
    ez_moo = 8'b0000_1001;
    es_def = '{1, 2, 3, 4, 2, 3, 4, 2};
    es_nov = '{1, 2, 3, 4, 0, 0, 1, 2};
    es_moo = '{1, 2, 3, 4, 5, 3, 4, 5};
    do_reset();
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      w_a = bits[7-i];
      #1;
      n_vec++; if (tick_def !== 1'b1) begin n_err++; $display("FAIL stream_tick[%0d]: got %b expected 1", i, tick_def); end
      n_vec++; if (z_def !== ez_def[7-i]) begin n_err++; $display("FAIL stream_z_def[%0d]: got %b expected %b", i, z_def, ez_def[7-i]); end
      n_vec++; if (z_nov !== ez_nov[7-i]) begin n_err++; $display("FAIL stream_z_nov[%0d]: got %b expected %b", i, z_nov, ez_nov[7-i]); end
      @(posedge clk);
      #1;
      n_vec++; if (st_def !== 3'(es_def[i])) begin n_err++; $display("FAIL stream_st_def[%0d]: got %0d expected %0d", i, st_def, es_def[i]); end
      n_vec++; if (st_nov !== 3'(es_nov[i])) begin n_err++; $display("FAIL stream_st_nov[%0d]: got %0d expected %0d", i, st_nov, es_nov[i]); end
      n_vec++; if (st_moo !== 3'(es_moo[i])) begin n_err++; $display("FAIL stream_st_moo[%0d]: got %0d expected %0d", i, st_moo, es_moo[i]); end
      n_vec++; if (z_moo !== ez_moo[7-i]) begin n_err++; $display("FAIL stream_z_moo[%0d]: got %b expected %b", i, z_moo, ez_moo[7-i]); end
    end
    n_vec++; if (cnt_def !== 8'(2*CNT_ON)) begin n_err++; $display("FAIL stream_cnt_def: got %0d expected %0d", cnt_def, 2*CNT_ON); end
    n_vec++; if (cnt_nov !== 8'(1*CNT_ON)) begin n_err++; $display("FAIL stream_cnt_nov: got %0d expected %0d", cnt_nov, CNT_ON); end
    n_vec++; if (cnt_moo !== 8'(2*CNT_ON)) begin n_err++; $display("FAIL stream_cnt_moo: got %0d expected %0d", cnt_moo, 2*CNT_ON); end
    n_vec++; if (tick_nov !== 1'b1 || tick_moo !== 1'b1) begin n_err++; $display("FAIL stream_tick_other: got %b%b expected 11", tick_nov, tick_moo); end
  endtask

  // 1,0,0,1 then an asynchronous reset pulse, then 0: no match may follow.
  task automatic test_mid_reset();
    logic [3:0] bits;
    bits = 4'b1001;
    do_reset();
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      w_a = bits[3-i];
      @(posedge clk);
    end
    #1;
    n_vec++; if (st_def !== 3'd4) begin n_err++; $display("FAIL midrst_pre_state: got %0d expected 4", st_def); end
    w_a = 1'b0;
    #1;
    n_vec++; if (z_def !== 1'b1) begin n_err++; $display("FAIL midrst_pre_z: got %b expected 1", z_def); end
    rest = 1'b0;
    #1;
    n_vec++; if (st_def !== 3'd0) begin n_err++; $display("FAIL midrst_async_state: got %0d expected 0", st_def); end
    n_vec++; if (z_def !== 1'b0) begin n_err++; $display("FAIL midrst_async_z: got %b expected 0", z_def); end
    @(negedge clk);
    rest = 1'b1;
    @(posedge clk);
    @(negedge clk);
    w_a = 1'b0;
    #1;
    n_vec++; if (z_def !== 1'b0) begin n_err++; $display("FAIL midrst_post_z: got %b expected 0", z_def); end
    @(posedge clk);
    #1;
    n_vec++; if (st_def !== 3'd0) begin n_err++; $display("FAIL midrst_post_state: got %0d expected 0", st_def); end
    n_vec++; if (cnt_def !== 8'd0) begin n_err++; $display("FAIL midrst_cnt: got %0d expected 0", cnt_def); end
  endtask

  // DIV=4: tick every fourth clk; optionally en=0 on the third tick.
  task automatic run_div(input logic gate3, input logic [4:0] ez, input int es0, input int es1,
                         input int es2, input int es3, input int es4);
    logic [4:0] bits;
    int es [5];
    int n;
    bits = 5'b10010;
    es   = '{es0, es1, es2, es3, es4};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!tick_div && n < 20);
      n_vec++; if (n !== 4) begin n_err++; $display("FAIL div_tick_spacing[%0d]: got %0d clks expected 4", i, n); end
      w_d  = bits[4-i];
      en_d = !(gate3 && i == 2);
      #1;
      n_vec++; if (z_div !== ez[4-i]) begin n_err++; $display("FAIL div_z[%0d]: got %b expected %b", i, z_div, ez[4-i]); end
      @(posedge clk);
      #1;
      en_d = 1'b1;
      n_vec++; if (st_div !== 3'(es[i])) begin n_err++; $display("FAIL div_state[%0d]: got %0d expected %0d", i, st_div, es[i]); end
    end
  endtask

  task automatic test_div();
    run_div(1'b0, 5'b00001, 1, 2, 3, 4, 2);
    n_vec++; if (cnt_div !== 8'(CNT_ON)) begin n_err++; $display("FAIL div_cnt: got %0d expected %0d", cnt_div, CNT_ON); end
    run_div(1'b1, 5'b00000, 1, 2, 2, 1, 2);
    n_vec++; if (cnt_div !== 8'd0) begin n_err++; $display("FAIL div_gated_cnt: got %0d expected 0", cnt_div); end
  endtask

  // 10010 five times into a non-overlapping detector with a 2-bit counter.
  task automatic test_saturate();
    logic [4:0] bits;
    int exp_cnt;
    bits = 5'b10010;
    do_reset();
    @(posedge clk);
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        w_c = bits[4-i];
        #1;
        if (i == 4) begin
          n_vec++; if (z_c !== 1'b1) begin n_err++; $display("FAIL sat_z[%0d]: got %b expected 1", r, z_c); end
        end
        @(posedge clk);
      end
      #1;
      exp_cnt = (r + 1 > 3) ? 3 : r + 1;
      exp_cnt = exp_cnt * CNT_ON;
      n_vec++; if (cnt_c !== 2'(exp_cnt)) begin n_err++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", r, cnt_c, exp_cnt); end
      n_vec++; if (st_c !== 3'd0) begin n_err++; $display("FAIL sat_state[%0d]: got %0d expected 0", r, st_c); end
    end
  endtask

  initial begin
    rest  = 1'b0;
    w_a   = 1'b0;
    w_d   = 1'b0;
    w_c   = 1'b0;
    en_on = 1'b1;
    en_d  = 1'b1;
    test_reset();
    test_stream();
    test_mid_reset();
    test_div();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial sequence detector; successor to the fixed 5-bit Mealy detectors used in the lab designs.
- Pattern value and length, Mealy/Moore output style and overlapping/non-overlapping detection are set by parameters.
- Built-in clock-enable divider replaces the separate divided clock: a single clock domain, with input sampled on an internal tick.
- Optional saturating match counter for board display/debug.

Parameters:
- PAT_LEN, 5, pattern length in bits, legal 2..16.
- PATTERN, 5'b10010, pattern bits; PATTERN[PAT_LEN-1] is the first bit received, PATTERN[0] the last.
- MOORE, 0, 0 = Mealy output, 1 = Moore output.
- OVERLAP, 1, 1 = overlapping matches allowed, 0 = state restarts at 0 after a match.
- DIV, 1, clk cycles per sample tick, legal 1..2^24; DIV=1 means sample every clk.
- CNT_W, 8, match counter width.

Ports:
- clk  in  1  system clock.
- rest  in  1  asynchronous active-low reset.
- w  in  1  serial data bit, sampled on tick.
- en  in  1  sampling enable; when 0, ticks are ignored (state frozen, divider keeps running).
- z  out  1  match indication (see Behaviour).
- tick  out  1  one-clk pulse marking each sample point.
- state  out  $clog2(PAT_LEN+1)  current FSM state, for debug.
- match_cnt  out  CNT_W  number of matches, saturating.

Behaviour:
- Reset (rest=0, asynchronous): divider count=0, state=0, match_cnt=0, tick=0; z=0 in Moore mode; in Mealy mode z=0 whenever state=0 (PAT_LEN>=2). Release is synchronous to the next clk edge.
- Divider: counts 0..DIV-1; tick=1 for exactly one clk when count==DIV-1; the first tick occurs DIV clks after reset release. With DIV=1, tick is held at 1.
- A sample occurs on any clk edge where tick=1 and en=1. Only samples change state or match_cnt.
- State meaning: state k means the last k sampled bits equal the first k pattern bits (the longest such prefix).
- Next state on a sample with bit b: the longest prefix of PATTERN that is a suffix of (current prefix followed by b). Precompute as a KMP-style table at elaboration; no run-time search.
- Mealy mode:
  - States 0..PAT_LEN-1.
  - z = (state==PAT_LEN-1) && (w==PATTERN[0]). Combinational, independent of tick and en.
  - On a matching sample, next state = failure value of the full pattern when OVERLAP=1, or 0 when OVERLAP=0.
- Moore mode:
  - States 0..PAT_LEN; state PAT_LEN means matched.
  - z = (state==PAT_LEN), registered; it stays high until the next sample.
  - Leaving PAT_LEN: consume b from the full-pattern failure value when OVERLAP=1, or from 0 when OVERLAP=0.
- Match event: a sample that completes the pattern. match_cnt increments by 1 on each match event and saturates at 2^CNT_W-1 (no wrap).
- Simultaneous events: reset dominates everything. en=0 on a tick causes no state change and no count.
- Mid-pattern reset: the partial prefix is discarded; detection restarts from state 0.
- Illegal state encodings (unused codes) go to 0 on the next sample.

Optional Feature:
- Macro: SEQ_DET_MATCH_CNT_EN.
- Defined: match counter implemented as described.
- Undefined: no counter flops; match_cnt is tied to 0. All other behaviour is identical.

Test Plan:
- Defaults (10010, Mealy, OVERLAP=1, DIV=1), w=1,0,0,1,0,0,1,0 on successive clks -> z high during samples 5 and 8; match_cnt=2.
- Same stream with OVERLAP=0 -> z high only at sample 5; match_cnt=1; state=0 after sample 5.
- MOORE=1, OVERLAP=1, same stream -> z high for the full clk after samples 5 and 8 (state=5); match_cnt=2.
- Drive 1,0,0,1 then pulse rest=0 mid-clk, then 0 -> state goes to 0 immediately; z stays 0; no match on the following 0.
- DIV=4 with w changing every 4 clks on tick, 1,0,0,1,0 -> tick every 4th clk; match at the 5th tick only. Repeat with en=0 on tick 3 -> no match; state unchanged across that tick.
- CNT_W=2, feed 10010 repeated 5 times non-overlapping -> match_cnt reaches 3 and holds. Macro undefined -> match_cnt=0 throughout.
